// File: rtl/button_input.sv
// ---------------------------------------------------------------------------
// button_input
//   Debounces a bouncy active-low push-button and turns it into a clean
//   level plus single-cycle event strobes and a 6-bit press counter.
//
//   Parameters
//     DEBOUNCE_CYCLES   : stable-sample count needed to accept a level change
//     LONG_PRESS_CYCLES : held-cycle count after which a long press is flagged
//
//   Ports
//     clk50         in   sole clock, rising edge
//     rst           in   synchronous, active-high reset
//     btn_n         in   raw button pin, active-low, asynchronous, bouncy
//     pressed       out  debounced level, 1 = held
//     press_pulse   out  one-cycle strobe on an accepted press
//     release_pulse out  one-cycle strobe on an accepted release
//     long_pulse    out  one-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//     press_count   out  accepted-press counter, wraps 63 -> 0
//
//   Handshake / timing: there is no valid/ready traffic here. Every output is
//   a register. An accepted transition is decided on one edge (an internal
//   *_evt flag is set) and becomes visible on the outputs on the following
//   edge, so the pulses and the pressed level change together.
// ---------------------------------------------------------------------------
module button_input #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [5:0] press_count
);

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        btn_s;
  logic [31:0] deb_timer;
  logic [31:0] hold_timer;
  logic        long_done;
  logic        press_evt;
  logic        release_evt;
  logic        long_evt;

  // Synchronised, active-high view of the button; the only consumer of btn_n
  // is the first synchroniser flop.
  assign btn_s = ~sync2;

  always_ff @(posedge clk50) begin
    if (rst) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      state         <= IDLE;
      deb_timer     <= '0;
      hold_timer    <= '0;
      long_done     <= 1'b0;
      press_evt     <= 1'b0;
      release_evt   <= 1'b0;
      long_evt      <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;

      // Output stage: reflect the decision made on the previous edge.
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      long_pulse    <= long_evt;
      if (press_evt) begin
        press_count <= press_count + 6'd1;
      end
      // DEB_RELEASE still counts as held: a release is only real once it
      // has survived the debounce window.
      pressed <= (state == HELD) || (state == LONG_HELD) ||
                 (state == DEB_RELEASE);

      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state     <= DEB_PRESS;
            deb_timer <= '0;
          end
        end

        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (deb_timer == DEB_LAST) begin
            state      <= HELD;
            hold_timer <= '0;
            press_evt  <= 1'b1;
          end else begin
            deb_timer <= deb_timer + 32'd1;
          end
        end

        HELD: begin
          // Release is tested first so a release arriving on the same cycle
          // the hold count completes suppresses the long-press strobe.
          if (!btn_s) begin
            state     <= DEB_RELEASE;
            deb_timer <= '0;
          end else if (hold_timer == LONG_LAST) begin
            state     <= LONG_HELD;
            long_evt  <= 1'b1;
            long_done <= 1'b1;
          end else begin
            hold_timer <= hold_timer + 32'd1;
          end
        end

        LONG_HELD: begin
          if (!btn_s) begin
            state     <= DEB_RELEASE;
            deb_timer <= '0;
          end
        end

        DEB_RELEASE: begin
          // long_done remembers which held state a rejected release glitch
          // returns to, so a long press never fires twice.
          if (btn_s) begin
            state <= long_done ? LONG_HELD : HELD;
          end else if (deb_timer == DEB_LAST) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            long_done   <= 1'b0;
          end else begin
            deb_timer <= deb_timer + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
